mips_mem_responder: RTL and testbench
=====================================

# mips_mem_responder

Byte-wide memory responder serving the 8-bit multicycle MIPS core's memory interface (adr / memread / memwrite / writedata → memdata). It also owns the core's reset. A host-side loader stream fills program memory while the core is held in reset, then releases it. A dump stream reads memory back after a halt. It sits between the Caravel IO wrapper and the `mips` instance.

## Interface
- WIDTH, 8, data and CPU address width
- AWIDTH, 5, memory address bits; depth DEPTH = 2^AWIDTH bytes
- clk  in  1  system clock (wb_clk_i at top)
- rst  in  1  asynchronous, active-low reset
- memread  in  1  CPU read strobe
- memwrite  in  1  CPU write strobe
- adr  in  WIDTH  CPU byte address
- writedata  in  WIDTH  CPU write data
- memdata  out  WIDTH  CPU read data
- cpu_reset  out  1  active-high reset to `mips`
- ld_valid  in  1  host load byte valid
- ld_ready  out  1  responder accepts load byte
- ld_data  in  WIDTH  load byte
- ld_last  in  1  marks final load byte
- stop  in  1  host request to halt the CPU
- dump_req  in  1  host request to stream memory out
- dump_valid  out  1  dump byte valid
- dump_ready  in  1  host accepts dump byte
- dump_data  out  WIDTH  dump byte
- adr_err  out  1  sticky: CPU accessed adr ≥ DEPTH

## Operation
- States: LOAD, RUN, HALT, DUMP. A single pointer `ptr[AWIDTH-1:0]` is shared by LOAD and DUMP.
- LOAD
  - ld_ready=1, cpu_reset=1.
  - On ld_valid&ld_ready: mem[ptr]←ld_data, ptr++.
  - If the accepted beat has ld_last=1 or ptr==DEPTH-1 → RUN, ptr←0.
- RUN
  - cpu_reset=0.
  - memdata = mem[adr[AWIDTH-1:0]] combinationally when memread=1 and adr<DEPTH; otherwise 0.
  - memwrite=1 with adr<DEPTH: mem[adr]←writedata at the clock edge.
  - memread or memwrite with adr≥DEPTH: the write is dropped, read returns 0, adr_err←1.
  - memread and memwrite together: read returns the pre-write contents.
  - stop=1 → HALT.
- HALT
  - cpu_reset=1.
  - dump_req=1 → DUMP with ptr←0.
  - Otherwise ld_valid=1 → LOAD with ptr←0; that byte is not accepted this cycle.
  - dump_req has priority over ld_valid.
- DUMP
  - dump_valid=1, dump_data=mem[ptr].
  - On dump_ready: ptr++.
  - The beat accepted at ptr==DEPTH-1 → HALT, ptr←0.
- Outside RUN, memread and memwrite are ignored and memdata=0.
- adr_err clears on entry to LOAD only.
- ld_valid, dump_req and stop in states where they have no meaning: ignored.

## Timing
- Reset values:
  - state=LOAD, ptr=0
  - cpu_reset=1, ld_ready=1
  - memdata=0
  - dump_valid=0, dump_data=0
  - adr_err=0
- Memory array is not reset; contents survive rst.
- Load throughput: 1 byte/cycle.
- RUN→CPU active: cpu_reset drops the cycle after the ld_last beat.
- CPU read: zero-latency combinational, valid in the same cycle memread and adr are presented.
- CPU write: visible to reads from the next cycle.
- stop: cpu_reset=1 from the next cycle; no CPU write is accepted after that edge.
- Dump: dump_data is stable while dump_valid=1 and dump_ready=0.
- Dump throughput: 1 byte/cycle when dump_ready is held high.
- rst mid-LOAD, mid-RUN or mid-DUMP: immediate return to LOAD with ptr=0 and cpu_reset=1.
- ptr wrap: it never wraps silently. Reaching DEPTH-1 terminates LOAD or DUMP.

## Structure
- Shared package `mips_mem_pkg`:
  - `memstate_t` enum {MS_LOAD, MS_RUN, MS_HALT, MS_DUMP}
  - DEPTH localparam derivation
- Sub-module `mem_array`: DEPTH×WIDTH register array with one write port and two asynchronous read ports (CPU, dump).
  - The write port is muxed by state: loader in LOAD, CPU in RUN.
- FSM, pointer, adr_err and output muxing live in `mips_mem_responder`.

## Test plan
- Reset, then load 4 bytes 0x80,0x20,0x01,0x05 with ld_last on the 4th → ld_ready high for 4 cycles; cpu_reset=0 on cycle 5; memread with adr=2 → memdata=0x01.
- Load DEPTH=32 bytes without ld_last → RUN entered after byte 31; byte 32 presented afterwards is not accepted.
- RUN: memwrite adr=0x07, writedata=0xA5 → memread adr=0x07 the next cycle returns 0xA5; with simultaneous read+write of 0x5A, the read shows 0xA5.
- RUN: memwrite adr=0x40 → adr_err=1 and memory unchanged; adr_err stays 1 through HALT and clears on re-entry to LOAD.
- stop, then dump_req with dump_ready toggling 1,0,1… → 32 bytes out in order with data held during stalls; returns to HALT after byte 31.
- Assert rst mid-DUMP at ptr=10 → state LOAD, dump_valid=0, cpu_reset=1; a subsequent dump (without reload) shows pre-reset contents.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared types and sizing helpers for the MIPS memory responder.
// The memory depth is derived from the address width so that every block sizes it the same way.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        MS_LOAD = 2'd0,
        MS_RUN  = 2'd1,
        MS_HALT = 2'd2,
        MS_DUMP = 2'd3
    } memstate_t;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_AWIDTH = 5;

    function automatic int depth_of(input int awidth);
        return 1 << awidth;
    endfunction

    localparam int DEF_DEPTH = depth_of(DEF_AWIDTH);

endpackage

// File: rtl/mem_array.sv
// DEPTH x WIDTH byte store: one synchronous write port and two asynchronous read ports.
// The CPU uses one read port and the dump stream uses the other.
module mem_array
    import mips_mem_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int AWIDTH = DEF_AWIDTH
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AWIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [AWIDTH-1:0] cpu_raddr,
    output logic [WIDTH-1:0]  cpu_rdata,
    input  logic [AWIDTH-1:0] dump_raddr,
    output logic [WIDTH-1:0]  dump_rdata
);

    localparam int DEPTH = depth_of(AWIDTH);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset on purpose; program contents must survive rst,
    // and leaving it unreset lets it map onto plain storage cells.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign cpu_rdata  = mem[cpu_raddr];
    assign dump_rdata = mem[dump_raddr];

endmodule

// File: rtl/mips_mem_responder.sv
// Memory responder for the 8-bit multicycle MIPS core: loads program bytes while the core
// is held in reset, serves CPU reads/writes while running, and streams memory out after a halt.
module mips_mem_responder
    import mips_mem_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int AWIDTH = DEF_AWIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             memread,
    input  logic             memwrite,
    input  logic [WIDTH-1:0] adr,
    input  logic [WIDTH-1:0] writedata,
    output logic [WIDTH-1:0] memdata,
    output logic             cpu_reset,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [WIDTH-1:0] ld_data,
    input  logic             ld_last,
    input  logic             stop,
    input  logic             dump_req,
    output logic             dump_valid,
    input  logic             dump_ready,
    output logic [WIDTH-1:0] dump_data,
    output logic             adr_err
);

    localparam int                DEPTH    = depth_of(AWIDTH);
    localparam logic [WIDTH:0]    DEPTH_W  = (WIDTH+1)'(DEPTH);
    localparam logic [AWIDTH-1:0] PTR_LAST = '1;

    memstate_t         state_q, state_d;
    logic [AWIDTH-1:0] ptr_q, ptr_d;
    logic              adr_err_q, adr_err_d;

    logic              mem_we;
    logic [AWIDTH-1:0] mem_waddr;
    logic [WIDTH-1:0]  mem_wdata;
    logic [WIDTH-1:0]  cpu_rdata;
    logic [WIDTH-1:0]  dump_rdata;
    logic              adr_in_range;

    assign adr_in_range = ({1'b0, adr} < DEPTH_W);

    mem_array #(
        .WIDTH (WIDTH),
        .AWIDTH(AWIDTH)
    ) u_mem (
        .clk       (clk),
        .we        (mem_we),
        .waddr     (mem_waddr),
        .wdata     (mem_wdata),
        .cpu_raddr (adr[AWIDTH-1:0]),
        .cpu_rdata (cpu_rdata),
        .dump_raddr(ptr_q),
        .dump_rdata(dump_rdata)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values no matter how the always_ff blocks are ordered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= MS_LOAD;
            ptr_q     <= '0;
            adr_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            adr_err_q <= adr_err_d;
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d    = state_q;
        ptr_d      = ptr_q;
        adr_err_d  = adr_err_q;
        cpu_reset  = 1'b1;
        ld_ready   = 1'b0;
        dump_valid = 1'b0;
        dump_data  = '0;
        memdata    = '0;
        mem_we     = 1'b0;
        mem_waddr  = ptr_q;
        mem_wdata  = ld_data;

        case (state_q)
            MS_LOAD: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    mem_we = 1'b1;
                    ptr_d  = ptr_q + AWIDTH'(1);
                    if (ld_last || ptr_q == PTR_LAST) begin
                        state_d = MS_RUN;
                        ptr_d   = '0;
                    end
                end
            end
            MS_RUN: begin
                cpu_reset = 1'b0;
                if (memread && adr_in_range) begin
                    memdata = cpu_rdata;
                end
                if (memwrite && adr_in_range) begin
                    mem_we    = 1'b1;
                    mem_waddr = adr[AWIDTH-1:0];
                    mem_wdata = writedata;
                end
                if ((memread || memwrite) && !adr_in_range) begin
                    adr_err_d = 1'b1;
                end
                if (stop) begin
                    state_d = MS_HALT;
                end
            end
            MS_HALT: begin
                // A dump request wins; a load byte seen here only reopens LOAD and is not stored.
                if (dump_req) begin
                    state_d = MS_DUMP;
                    ptr_d   = '0;
                end else if (ld_valid) begin
                    state_d   = MS_LOAD;
                    ptr_d     = '0;
                    adr_err_d = 1'b0;
                end
            end
            MS_DUMP: begin
                dump_valid = 1'b1;
                dump_data  = dump_rdata;
                if (dump_ready) begin
                    ptr_d = ptr_q + AWIDTH'(1);
                    if (ptr_q == PTR_LAST) begin
                        state_d = MS_HALT;
                        ptr_d   = '0;
                    end
                end
            end
            default: begin
                state_d = MS_LOAD;
                ptr_d   = '0;
            end
        endcase
    end

    assign adr_err = adr_err_q;

endmodule

// File: tb/tb_mips_mem_responder.sv
// Directed self-checking bench for mips_mem_responder: load, run, error, halt, dump and
// reset-persistence scenarios with hand-computed expectations.
module tb_mips_mem_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic       memread, memwrite;
    logic [7:0] adr, writedata, memdata;
    logic       cpu_reset;
    logic       ld_valid, ld_ready, ld_last;
    logic [7:0] ld_data;
    logic       stop, dump_req, dump_valid, dump_ready;
    logic [7:0] dump_data;
    logic       adr_err;

    int         n_assert = 0;
    int         n_fail   = 0;
    logic [7:0] exp_mem [32];

    always #5 clk = ~clk;

    mips_mem_responder #(.WIDTH(8), .AWIDTH(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .memread   (memread),
        .memwrite  (memwrite),
        .adr       (adr),
        .writedata (writedata),
        .memdata   (memdata),
        .cpu_reset (cpu_reset),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_data   (ld_data),
        .ld_last   (ld_last),
        .stop      (stop),
        .dump_req  (dump_req),
        .dump_valid(dump_valid),
        .dump_ready(dump_ready),
        .dump_data (dump_data),
        .adr_err   (adr_err)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_assert++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns later, well clear of the rising edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        memread = 0; memwrite = 0; adr = 0; writedata = 0;
        ld_valid = 0; ld_data = 0; ld_last = 0;
        stop = 0; dump_req = 0; dump_ready = 0;
    endtask

    task automatic dump_all(input string tag, input bit toggle);
        int k = 0;
        int cyc = 0;
        while (k < 32 && cyc < 100) begin
            step();
            dump_req   = 0;
            dump_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            #1;
            check({tag, "_valid"}, dump_valid, 1'b1);
            check({tag, "_data"}, dump_data, exp_mem[k]);
            if (dump_ready) k++;
            cyc++;
        end
        check({tag, "_count"}, k, 32);
        step();
        dump_ready = 0;
        #1;
        check({tag, "_done_valid"}, dump_valid, 1'b0);
        check({tag, "_done_cpu_reset"}, cpu_reset, 1'b1);
    endtask

    initial begin
        idle_inputs();
        rst = 0;

        // Reset values; a read strobe during reset must still return 0.
        memread = 1; adr = 8'h00;
        repeat (2) step();
        #1;
        check("rst_cpu_reset", cpu_reset, 1'b1);
        check("rst_ld_ready", ld_ready, 1'b1);
        check("rst_memdata", memdata, 8'h00);
        check("rst_dump_valid", dump_valid, 1'b0);
        check("rst_dump_data", dump_data, 8'h00);
        check("rst_adr_err", adr_err, 1'b0);
        step();
        rst = 1; memread = 0;

        // Load 4 bytes with ld_last on the last one.
        begin
            logic [7:0] prog [4];
            prog[0] = 8'h80; prog[1] = 8'h20; prog[2] = 8'h01; prog[3] = 8'h05;
            for (int i = 0; i < 4; i++) begin
                step();
                ld_valid = 1; ld_data = prog[i]; ld_last = (i == 3);
                #1;
                check("load4_ld_ready", ld_ready, 1'b1);
                check("load4_cpu_reset", cpu_reset, 1'b1);
            end
        end
        step();
        ld_valid = 0; ld_last = 0;
        memread = 1; adr = 8'h02;
        #1;
        check("run_cpu_reset", cpu_reset, 1'b0);
        check("run_ld_ready", ld_ready, 1'b0);
        check("run_read_adr2", memdata, 8'h01);

        // Out-of-range access: read returns 0, write dropped, adr_err set.
        step();
        memread = 1; memwrite = 1; adr = 8'h40; writedata = 8'hFF;
        #1;
        check("oor_read_zero", memdata, 8'h00);
        step();
        memwrite = 0; memread = 1; adr = 8'h00;
        #1;
        check("oor_adr_err", adr_err, 1'b1);
        check("oor_mem_unchanged", memdata, 8'h80);

        // stop -> HALT; adr_err sticky; CPU read ignored.
        step();
        memread = 0; stop = 1;
        step();
        stop = 0; memread = 1; adr = 8'h00;
        #1;
        check("halt_cpu_reset", cpu_reset, 1'b1);
        check("halt_adr_err", adr_err, 1'b1);
        check("halt_memdata", memdata, 8'h00);
        check("halt_ld_ready", ld_ready, 1'b0);

        // ld_valid in HALT reopens LOAD without taking the byte.
        step();
        memread = 0; ld_valid = 1; ld_data = 8'h99;
        #1;
        check("halt_ld_not_ready", ld_ready, 1'b0);

        // Full 32-byte load without ld_last.
        for (int i = 0; i < 32; i++) begin
            exp_mem[i] = 8'((i * 7 + 3) & 8'hFF);
            step();
            ld_valid = 1; ld_data = exp_mem[i]; ld_last = 0;
            #1;
            check("load32_ld_ready", ld_ready, 1'b1);
            if (i == 0) check("load_adr_err_cleared", adr_err, 1'b0);
        end
        step();
        ld_valid = 1; ld_data = 8'hEE;
        memread = 1; adr = 8'h00;
        #1;
        check("load32_extra_not_ready", ld_ready, 1'b0);
        check("load32_run", cpu_reset, 1'b0);
        check("load32_byte0", memdata, exp_mem[0]);
        adr = 8'h1F;
        #1;
        check("load32_byte31", memdata, exp_mem[31]);

        // Write then read back; simultaneous read+write returns pre-write data.
        step();
        ld_valid = 0; memread = 0; memwrite = 1; adr = 8'h07; writedata = 8'hA5;
        step();
        memwrite = 0; memread = 1;
        #1;
        check("wr_then_rd", memdata, 8'hA5);
        step();
        memwrite = 1; writedata = 8'h5A;
        #1;
        check("rdwr_pre_write", memdata, 8'hA5);
        step();
        memwrite = 0;
        #1;
        check("rdwr_post_write", memdata, 8'h5A);
        exp_mem[7] = 8'h5A;

        // Halt, try a write in HALT (ignored), then dump with dump_ready toggling.
        step();
        memread = 0; stop = 1;
        step();
        stop = 0; memwrite = 1; adr = 8'h01; writedata = 8'hEE;
        #1;
        check("halt2_cpu_reset", cpu_reset, 1'b1);
        check("halt2_dump_valid", dump_valid, 1'b0);
        step();
        memwrite = 0; dump_req = 1;
        dump_all("dump_toggle", 1'b1);

        // Second dump interrupted by rst at ptr=10.
        step();
        dump_req = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            dump_req = 0; dump_ready = 1;
        end
        step();
        dump_ready = 0;
        #1;
        check("pre_rst_ptr10_data", dump_data, exp_mem[10]);
        rst = 0;
        #1;
        check("mid_rst_dump_valid", dump_valid, 1'b0);
        check("mid_rst_cpu_reset", cpu_reset, 1'b1);
        check("mid_rst_ld_ready", ld_ready, 1'b1);
        step();
        rst = 1;

        // Minimal reload of byte 0 only, then dump: the rest must be pre-reset contents.
        step();
        ld_valid = 1; ld_data = 8'h42; ld_last = 1;
        #1;
        check("reload_ld_ready", ld_ready, 1'b1);
        exp_mem[0] = 8'h42;
        step();
        ld_valid = 0; ld_last = 0; stop = 1;
        #1;
        check("reload_run", cpu_reset, 1'b0);
        step();
        stop = 0; dump_req = 1;
        dump_all("dump_persist", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no end of test, expected finish");
        $fatal(1, "timeout");
    end

endmodule
